// File: rtl/adma_controller.sv
// ADMA2 descriptor sequencer: fetches 96-bit descriptors, programs the transfer
// engine, and owns the shared RAM read port outside of data transfers.
module adma_controller #(
    parameter int unsigned DESC_BYTES = 12
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic        stop,
    input  logic        direction,
    input  logic [63:0] desc_base,
    input  logic [31:0] data_from_ram,
    input  logic        tr_tfc,
    input  logic        tr_ram_read,
    input  logic [63:0] tr_ram_address,
    output logic        ram_read,
    output logic [63:0] ram_address,
    output logic        tr_start,
    output logic        tr_direction,
    output logic [63:0] tr_address,
    output logic [15:0] tr_length,
    output logic        busy,
    output logic        done,
    output logic        int_req,
    output logic        adma_error,
    output logic [1:0]  error_state,
    output logic [63:0] cur_desc_addr
);

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 16;

    localparam logic [1:0] ACT_TRAN = 2'b10;
    localparam logic [1:0] ACT_LINK = 2'b11;

    typedef enum logic [4:0] {
        ST_STOP = 5'b00001,
        ST_FDS  = 5'b00010,
        ST_CADR = 5'b00100,
        ST_TFR  = 5'b01000,
        ST_ERR  = 5'b10000
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                desc_valid_q, desc_valid_d;
    logic                desc_end_q, desc_end_d;
    logic                desc_int_q, desc_int_d;
    logic [1:0]          desc_act_q, desc_act_d;
    logic [LEN_W-1:0]    desc_len_q, desc_len_d;
    logic [DATA_W-1:0]   addr_lo_q, addr_lo_d;
    logic [DATA_W-1:0]   addr_hi_q, addr_hi_d;
    logic                fetch_rd_q, fetch_rd_d;
    logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
    logic                tr_start_q, tr_start_d;
    logic                tr_dir_q, tr_dir_d;
    logic [ADDR_W-1:0]   tr_addr_q, tr_addr_d;
    logic [LEN_W-1:0]    tr_len_q, tr_len_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                int_req_q, int_req_d;
    logic                err_q, err_d;
    logic [1:0]          err_state_q, err_state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic                tfc_armed_q, tfc_armed_d;
    logic                stop_pend_q, stop_pend_d;

    logic                go_fetch;
    logic [ADDR_W-1:0]   fetch_tgt;
    logic [ADDR_W-1:0]   next_desc;

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        desc_valid_d = desc_valid_q;
        desc_end_d   = desc_end_q;
        desc_int_d   = desc_int_q;
        desc_act_d   = desc_act_q;
        desc_len_d   = desc_len_q;
        addr_lo_d    = addr_lo_q;
        addr_hi_d    = addr_hi_q;
        fetch_rd_d   = 1'b0;
        fetch_addr_d = fetch_addr_q;
        tr_start_d   = 1'b0;
        tr_dir_d     = tr_dir_q;
        tr_addr_d    = tr_addr_q;
        tr_len_d     = tr_len_q;
        done_d       = 1'b0;
        int_req_d    = 1'b0;
        err_d        = err_q;
        err_state_d  = err_state_q;
        cur_d        = cur_q;
        tfc_armed_d  = tfc_armed_q;
        stop_pend_d  = stop_pend_q;
        go_fetch     = 1'b0;
        fetch_tgt    = cur_q;
        next_desc    = cur_q + ADDR_W'(DESC_BYTES);

        case (state_q)
            ST_STOP, ST_ERR: begin
                if (start && !stop) begin
                    go_fetch    = 1'b1;
                    fetch_tgt   = desc_base & ~ADDR_W'(3);
                    tr_dir_d    = direction;
                    err_d       = 1'b0;
                    err_state_d = 2'b00;
                end
            end
            ST_FDS: begin
                if (stop) begin
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                    case (cnt_q)
                        2'd0: begin
                            fetch_rd_d   = 1'b1;
                            fetch_addr_d = cur_q + ADDR_W'(4);
                        end
                        2'd1: begin
                            desc_valid_d = data_from_ram[0];
                            desc_end_d   = data_from_ram[1];
                            desc_int_d   = data_from_ram[2];
                            desc_act_d   = data_from_ram[5:4];
                            desc_len_d   = data_from_ram[31:16];
                            fetch_rd_d   = 1'b1;
                            fetch_addr_d = cur_q + ADDR_W'(8);
                        end
                        2'd2: addr_lo_d = data_from_ram;
                        default: begin
                            addr_hi_d = data_from_ram;
                            state_d   = ST_CADR;
                            // Transfer is launched as the decode cycle begins
                            if (desc_valid_q && desc_act_q == ACT_TRAN) begin
                                tr_start_d = 1'b1;
                                tr_addr_d  = {data_from_ram, addr_lo_q};
                                tr_len_d   = desc_len_q;
                            end
                        end
                    endcase
                end
            end
            ST_CADR: begin
                tfc_armed_d = 1'b0;
                stop_pend_d = 1'b0;
                if (stop) begin
                    state_d = ST_STOP;
                end else if (!desc_valid_q) begin
                    err_d       = 1'b1;
                    err_state_d = 2'b01;
                    state_d     = ST_ERR;
                end else if (desc_act_q == ACT_TRAN) begin
                    state_d = ST_TFR;
                end else if (desc_act_q == ACT_LINK) begin
                    go_fetch  = 1'b1;
                    fetch_tgt = {addr_hi_q, addr_lo_q} & ~ADDR_W'(3);
                end else if (desc_end_q) begin
                    done_d  = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    go_fetch  = 1'b1;
                    fetch_tgt = next_desc;
                end
            end
            ST_TFR: begin
                // First cycle ignores the stale idle TFC of the transfer engine
                tfc_armed_d = 1'b1;
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (tfc_armed_q && tr_tfc) begin
                    if (stop_pend_q || stop) begin
                        state_d = ST_STOP;
                    end else begin
                        int_req_d = desc_int_q;
                        if (desc_end_q) begin
                            done_d  = 1'b1;
                            state_d = ST_STOP;
                        end else begin
                            go_fetch  = 1'b1;
                            fetch_tgt = next_desc;
                        end
                    end
                end
            end
            default: state_d = ST_STOP;
        endcase

        if (go_fetch) begin
            state_d      = ST_FDS;
            cnt_d        = 2'd0;
            cur_d        = fetch_tgt;
            fetch_rd_d   = 1'b1;
            fetch_addr_d = fetch_tgt;
        end

        busy_d = (state_d != ST_STOP) && (state_d != ST_ERR);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_STOP;
            cnt_q        <= 2'd0;
            desc_valid_q <= 1'b0;
            desc_end_q   <= 1'b0;
            desc_int_q   <= 1'b0;
            desc_act_q   <= 2'b00;
            desc_len_q   <= '0;
            addr_lo_q    <= '0;
            addr_hi_q    <= '0;
            fetch_rd_q   <= 1'b0;
            fetch_addr_q <= '0;
            tr_start_q   <= 1'b0;
            tr_dir_q     <= 1'b0;
            tr_addr_q    <= '0;
            tr_len_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            int_req_q    <= 1'b0;
            err_q        <= 1'b0;
            err_state_q  <= 2'b00;
            cur_q        <= '0;
            tfc_armed_q  <= 1'b0;
            stop_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            desc_valid_q <= desc_valid_d;
            desc_end_q   <= desc_end_d;
            desc_int_q   <= desc_int_d;
            desc_act_q   <= desc_act_d;
            desc_len_q   <= desc_len_d;
            addr_lo_q    <= addr_lo_d;
            addr_hi_q    <= addr_hi_d;
            fetch_rd_q   <= fetch_rd_d;
            fetch_addr_q <= fetch_addr_d;
            tr_start_q   <= tr_start_d;
            tr_dir_q     <= tr_dir_d;
            tr_addr_q    <= tr_addr_d;
            tr_len_q     <= tr_len_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            int_req_q    <= int_req_d;
            err_q        <= err_d;
            err_state_q  <= err_state_d;
            cur_q        <= cur_d;
            tfc_armed_q  <= tfc_armed_d;
            stop_pend_q  <= stop_pend_d;
        end
    end

    // RAM port belongs to the transfer engine only while a transfer runs
    assign ram_read      = (state_q == ST_TFR) ? tr_ram_read    : fetch_rd_q;
    assign ram_address   = (state_q == ST_TFR) ? tr_ram_address : fetch_addr_q;

    assign tr_start      = tr_start_q;
    assign tr_direction  = tr_dir_q;
    assign tr_address    = tr_addr_q;
    assign tr_length     = tr_len_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign int_req       = int_req_q;
    assign adma_error    = err_q;
    assign error_state   = err_state_q;
    assign cur_desc_addr = cur_q;

endmodule
